ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Receives scan-code set 2 frames from a PS/2 keyboard and converts make/break sequences into a held-key interface.
- Sits directly upstream of the VGA visualiser. It drives key_code, key_valid and key_released, which select note colour and bar activity there.
- Also exposes the raw received byte stream and an error pulse for debug LEDs.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples needed before the filtered PS2 clock/data level changes.
- TIMEOUT_CYCLES, 200000: CLK100MHZ cycles (2 ms) allowed between falling edges inside a frame before the frame is aborted.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- CPU_RESETN  in  1  reset; asynchronous assert, active-low.
- PS2_CLK  in  1  keyboard clock; asynchronous, open-drain.
- PS2_DATA  in  1  keyboard data; asynchronous.
- key_code  out  8  make code of the currently or most recently held key.
- key_ext  out  1  key_code was preceded by an E0 prefix.
- key_valid  out  1  level; high while the key in key_code is held.
- key_released  out  1  one-cycle pulse when the held key's break sequence completes.
- rx_byte  out  8  last correctly received byte.
- rx_strobe  out  1  one-cycle pulse; rx_byte has just been updated.
- frame_err  out  1  one-cycle pulse on parity error, stop-bit error or timeout.

Behaviour:
- Clock and reset:
  - One clock, CLK100MHZ. CPU_RESETN is asynchronous active-low; all flops clear immediately on assertion.
  - Reset values: every output is 0. Internal FSM returns to IDLE, and the prefix flags and bit counter are cleared.
  - A reset mid-frame discards the partial frame; no strobe or error is generated.
- Input conditioning:
  - PS2_CLK and PS2_DATA each pass through a 2-FF synchroniser, then the glitch filter.
  - The filtered level is initialised to 1 and updates only after FILTER_LEN consecutive equal samples.
  - Falling-edge detect on the filtered clock produces a 1-cycle sample pulse; data is taken from the filtered data at that pulse.
- Frame FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE: a sample with data=0 moves to DATA with the bit counter at 0. A sample with data=1 is ignored and stays in IDLE.
  - DATA: shift 8 bits LSB first; after the 8th bit, move to PARITY.
  - PARITY: store the bit and move to STOP.
  - STOP: the frame is accepted if the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
    - Accepted: in the next cycle rx_byte is loaded and rx_strobe pulses.
    - Rejected: frame_err pulses instead.
    - Either way, return to IDLE.
  - Timeout: in any state other than IDLE, a counter runs and is cleared on each sample pulse. At TIMEOUT_CYCLES it forces IDLE and pulses frame_err once. The counter is 18 bits, saturating.
- Protocol layer (acts only on the rx_strobe cycle; outputs update one cycle later):
  - E0: set ext_pending.
  - F0: set brk_pending.
  - Ignored bytes: 00, AA, EE, FA, FC, FE, FF. These clear both pending flags and change no outputs.
  - Other byte with brk_pending=1: break sequence.
    - If key_valid=1, byte==key_code and ext_pending==key_ext: key_valid becomes 0 and key_released pulses for 1 cycle.
    - Otherwise (release of a non-held key): no output change.
    - Both flags cleared.
  - Other byte with brk_pending=0: make sequence.
    - key_code is set to the byte, key_ext to ext_pending, key_valid to 1, and both flags are cleared.
    - Typematic repeats of the same make code keep key_valid high with no glitch.
    - A make for a different key replaces key_code (last-pressed wins). The earlier key's later break is then ignored.
- Simultaneous events: key_released and a make can never occur together because bytes are serialised. frame_err and rx_strobe are mutually exclusive.
- Latency:
  - The last filtered falling edge (stop bit) leads to rx_strobe after 1 cycle, and to key_* after 2 cycles.
  - Overall, about FILTER_LEN+4 cycles from the raw PS2_CLK edge.

Decomposition:
- Shared package ps2_pkg holds:
  - Byte constants: PS2_BREAK=8'hF0, PS2_EXT=8'hE0, and the ignored-byte list.
  - The frame FSM state enum.
  - The PS2 keyboard make codes used elsewhere (1A 22 21 2A 32 31 3A 3B).
- Natural sub-module: ps2_rx_frame. It contains the synchroniser, filter, edge detect, frame FSM and timeout, and outputs rx_byte, rx_strobe and frame_err. The top level adds the make/break layer.

Test Plan:
- Bus model (applies to all scenarios): 12.5 kHz clock, data changed mid-high.
- Send frame 0x1A with parity 0 and stop 1:
  - rx_strobe pulses once with rx_byte=1A.
  - key_code=1A, key_valid=1 and key_ext=0 one cycle later.
- Send 1A, then F0 1A:
  - key_valid falls to 0 and key_released is high for exactly 1 cycle.
  - key_code stays 1A.
- Send 1A, then 22, then F0 1A:
  - key_code=22 and key_valid stays 1.
  - No key_released pulse; it fires only after F0 22.
- Send E0 74, then F0 74:
  - After E0 74: key_ext=1 and key_code=74.
  - A plain F0 74 is ignored.
  - E0 F0 74 releases the key.
- Error and timeout cases:
  - Frame 0x1A with parity bit 1: frame_err pulses and outputs are unchanged.
  - Stop bit 0: frame_err pulses.
  - Stop the clock after 5 bits: frame_err pulses once at 200000 cycles, then the next valid frame decodes.
- Robustness:
  - Inject 3-cycle low glitches on PS2_CLK while idle: no state change.
  - Assert CPU_RESETN=0 mid-frame: all outputs are 0 immediately, and the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 scan-code set 2 shared definitions.
// Byte constants, frame FSM states and the note keys.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] NOTE_KEYS [8] = '{
    8'h1A, 8'h22, 8'h21, 8'h2A,
    8'h32, 8'h31, 8'h3A, 8'h3B
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  // Acks, BAT results and echo bytes carry no key information
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA,
      8'hFC, 8'hFE, 8'hFF: is_ignored = 1'b1;
      default:             is_ignored = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: sync, glitch filter, edge detect,
// 11-bit frame FSM with odd parity check and timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_strobe,
  output logic       o_frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam logic [17:0] TMO = 18'(TIMEOUT_CYCLES - 1);

  logic [1:0]    r_cs, r_ds;
  logic [FW-1:0] r_ccnt, r_dcnt;
  logic          r_fclk, r_fdat, r_fclk_d;
  rx_state_e     r_state, w_nstate;
  logic [2:0]    r_bcnt;
  logic [7:0]    r_shift, r_byte;
  logic          r_par, r_stb, r_err;
  logic [17:0]   r_tcnt;
  logic          w_smp, w_bit, w_ok, w_bad, w_tmo;

  assign w_smp = r_fclk_d & ~r_fclk;
  assign w_bit = r_fdat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cs     <= 2'b11;
      r_ds     <= 2'b11;
      r_ccnt   <= '0;
      r_dcnt   <= '0;
      r_fclk   <= 1'b1;
      r_fdat   <= 1'b1;
      r_fclk_d <= 1'b1;
    end else begin
      r_cs     <= {r_cs[0], i_ps2_clk};
      r_ds     <= {r_ds[0], i_ps2_data};
      r_fclk_d <= r_fclk;
      if (r_cs[1] == r_fclk) begin
        r_ccnt <= '0;
      end else if (r_ccnt == FMAX) begin
        r_fclk <= r_cs[1];
        r_ccnt <= '0;
      end else begin
        r_ccnt <= r_ccnt + 1'b1;
      end
      if (r_ds[1] == r_fdat) begin
        r_dcnt <= '0;
      end else if (r_dcnt == FMAX) begin
        r_fdat <= r_ds[1];
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ok     = 1'b0;
    w_bad    = 1'b0;
    w_tmo    = (r_state != S_IDLE) && (r_tcnt >= TMO);
    if (w_smp) begin
      unique case (r_state)
        S_IDLE:   if (!w_bit) w_nstate = S_DATA;
        S_DATA:   if (r_bcnt == 3'd7) w_nstate = S_PARITY;
        S_PARITY: w_nstate = S_STOP;
        S_STOP: begin
          w_nstate = S_IDLE;
          w_ok     = w_bit & (^{r_shift, r_par});
          w_bad    = ~w_ok;
        end
        default:  w_nstate = S_IDLE;
      endcase
    end else if (w_tmo) begin
      w_nstate = S_IDLE;
      w_bad    = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_byte  <= '0;
      r_stb   <= 1'b0;
      r_err   <= 1'b0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_nstate;
      r_stb   <= w_ok;
      r_err   <= w_bad;
      if (w_ok) r_byte <= r_shift;
      if (w_smp && r_state == S_IDLE) r_bcnt <= '0;
      if (w_smp && r_state == S_DATA) begin
        r_shift <= {w_bit, r_shift[7:1]};
        r_bcnt  <= r_bcnt + 1'b1;
      end
      if (w_smp && r_state == S_PARITY) r_par <= w_bit;
      if (r_state == S_IDLE || w_smp) r_tcnt <= '0;
      else if (r_tcnt != '1) r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign o_rx_byte   = r_byte;
  assign o_rx_strobe = r_stb;
  assign o_frame_err = r_err;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: turns make/break byte sequences
// into a held-key interface for the visualiser.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_valid,
  output logic       key_released,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);

  logic [7:0] w_byte;
  logic       w_stb, w_err;
  logic       w_is_ext, w_is_brk, w_is_ign, w_other;
  logic       w_brk_seq, w_make, w_match;
  logic [7:0] r_code;
  logic       r_ext, r_valid, r_rel, r_extp, r_brkp;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .i_clk       (CLK100MHZ),
    .i_rst_n     (CPU_RESETN),
    .i_ps2_clk   (PS2_CLK),
    .i_ps2_data  (PS2_DATA),
    .o_rx_byte   (w_byte),
    .o_rx_strobe (w_stb),
    .o_frame_err (w_err)
  );

  assign w_is_ext  = (w_byte == PS2_EXT);
  assign w_is_brk  = (w_byte == PS2_BREAK);
  assign w_is_ign  = is_ignored(w_byte);
  assign w_other   = ~(w_is_ext | w_is_brk | w_is_ign);
  assign w_brk_seq = w_other & r_brkp;
  assign w_make    = w_other & ~r_brkp;
  assign w_match   = r_valid & (w_byte == r_code) & (r_extp == r_ext);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_code  <= '0;
      r_ext   <= 1'b0;
      r_valid <= 1'b0;
      r_rel   <= 1'b0;
      r_extp  <= 1'b0;
      r_brkp  <= 1'b0;
    end else begin
      r_rel <= 1'b0;
      if (w_stb) begin
        unique case (1'b1)
          w_is_ext: r_extp <= 1'b1;
          w_is_brk: r_brkp <= 1'b1;
          w_is_ign: begin
            r_extp <= 1'b0;
            r_brkp <= 1'b0;
          end
          w_brk_seq: begin
            if (w_match) begin
              r_valid <= 1'b0;
              r_rel   <= 1'b1;
            end
            r_extp <= 1'b0;
            r_brkp <= 1'b0;
          end
          w_make: begin
            r_code  <= w_byte;
            r_ext   <= r_extp;
            r_valid <= 1'b1;
            r_extp  <= 1'b0;
            r_brkp  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign key_code     = r_code;
  assign key_ext      = r_ext;
  assign key_valid    = r_valid;
  assign key_released = r_rel;
  assign rx_byte      = w_byte;
  assign rx_strobe    = w_stb;
  assign frame_err    = w_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed plus randomized bench for ps2_key_decoder with a
// byte-level keyboard model; bus timing scaled down for sim.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int HP  = 40;
  localparam int TMO = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] key_code, rx_byte;
  logic       key_ext, key_valid, key_released;
  logic       rx_strobe, frame_err;

  int checks = 0;
  int errors = 0;
  int n_stb = 0, n_err = 0, n_rel = 0;
  int exp_stb = 0, exp_err = 0, exp_rel = 0;
  logic       d_stb = 1'b0;
  logic [7:0] snap_code = 8'h00;
  logic       snap_valid = 1'b0;

  logic [7:0] m_code = 8'h00, m_rx = 8'h00;
  logic       m_ext = 1'b0, m_valid = 1'b0;
  logic       m_extp = 1'b0, m_brkp = 1'b0;

  ps2_key_decoder #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK100MHZ    (clk),
    .CPU_RESETN   (rst_n),
    .PS2_CLK      (ps2_clk),
    .PS2_DATA     (ps2_dat),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_valid    (key_valid),
    .key_released (key_released),
    .rx_byte      (rx_byte),
    .rx_strobe    (rx_strobe),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_strobe) n_stb++;
    if (frame_err) n_err++;
    if (key_released) n_rel++;
    if (d_stb) begin
      snap_code  = key_code;
      snap_valid = key_valid;
    end
    d_stb = rx_strobe;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(HP / 2);
      ps2_dat = f[i];
      cyc(HP / 2);
      ps2_clk = 1'b0;
      cyc(HP);
      ps2_clk = 1'b1;
    end
    cyc(HP / 2);
    ps2_dat = 1'b1;
    cyc(30);
  endtask

  // Keyboard-level meaning of one accepted byte
  task automatic model_byte(input logic [7:0] b);
    exp_stb++;
    m_rx = b;
    if (b == 8'hE0) m_extp = 1'b1;
    else if (b == 8'hF0) m_brkp = 1'b1;
    else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA,
                       8'hFC, 8'hFE, 8'hFF}) begin
      m_extp = 1'b0;
      m_brkp = 1'b0;
    end else if (m_brkp) begin
      if (m_valid && b == m_code && m_extp == m_ext) begin
        m_valid = 1'b0;
        exp_rel++;
      end
      m_extp = 1'b0;
      m_brkp = 1'b0;
    end else begin
      m_code  = b;
      m_ext   = m_extp;
      m_valid = 1'b1;
      m_extp  = 1'b0;
      m_brkp  = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic pflip,
                      input logic stop);
    logic par;
    par = (~^b) ^ pflip;
    send_bits({stop, par, b, 1'b0}, 11);
    if (!pflip && stop) model_byte(b);
    else exp_err++;
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    chk({tag, ".rx_byte"}, 32'(rx_byte), 32'(m_rx));
    chk({tag, ".strobes"}, 32'(n_stb), 32'(exp_stb));
    chk({tag, ".errs"}, 32'(n_err), 32'(exp_err));
    chk({tag, ".releases"}, 32'(n_rel), 32'(exp_rel));
    chk({tag, ".key_code"}, 32'(key_code), 32'(m_code));
    chk({tag, ".key_ext"}, 32'(key_ext), 32'(m_ext));
    chk({tag, ".key_valid"}, 32'(key_valid), 32'(m_valid));
  endtask

  initial begin
    logic [7:0] pool [14];
    logic [7:0] b;
    int k;

    cyc(5);
    rst_n = 1'b1;
    cyc(3);
    check_all("reset");
    chk("reset.rx_strobe", 32'(rx_strobe), 32'd0);
    chk("reset.frame_err", 32'(frame_err), 32'd0);
    chk("reset.key_released", 32'(key_released), 32'd0);

    send(8'h1A, 1'b0, 1'b0 == 1'b0);
    chk("make.latency_code", 32'(snap_code), 32'h1A);
    chk("make.latency_valid", 32'(snap_valid), 32'd1);
    check_all("make_1A");

    send(8'hF0, 1'b0, 1'b1);
    send(8'h1A, 1'b0, 1'b1);
    check_all("break_1A");

    send(8'h1A, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    send(8'hF0, 1'b0, 1'b1);
    send(8'h1A, 1'b0, 1'b1);
    check_all("stale_break");
    send(8'hF0, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    check_all("break_22");

    send(8'hE0, 1'b0, 1'b1);
    send(8'h74, 1'b0, 1'b1);
    check_all("ext_make");
    send(8'hF0, 1'b0, 1'b1);
    send(8'h74, 1'b0, 1'b1);
    check_all("plain_break_ext");
    send(8'hE0, 1'b0, 1'b1);
    send(8'hF0, 1'b0, 1'b1);
    send(8'h74, 1'b0, 1'b1);
    check_all("ext_break");

    send(8'h3B, 1'b0, 1'b1);
    send(8'h1A, 1'b1, 1'b1);
    check_all("parity_err");
    send(8'h1A, 1'b0, 1'b0);
    check_all("stop_err");

    send_bits({3'b111, 8'h1A, 1'b0}, 5);
    k = 0;
    while (n_err == exp_err && k < 4 * TMO) begin
      cyc(1);
      k++;
    end
    exp_err++;
    cyc(2 * TMO);
    check_all("timeout");
    send(8'h32, 1'b0, 1'b1);
    check_all("after_timeout");

    for (int i = 0; i < 6; i++) begin
      ps2_clk = 1'b0;
      cyc(3);
      ps2_clk = 1'b1;
      cyc(25);
    end
    check_all("glitch");
    send(8'h31, 1'b0, 1'b1);
    check_all("after_glitch");

    send_bits({3'b111, 8'h2A, 1'b0}, 4);
    ps2_clk = 1'b0;
    cyc(HP / 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset.key_code", 32'(key_code), 32'd0);
    chk("midreset.key_valid", 32'(key_valid), 32'd0);
    chk("midreset.rx_byte", 32'(rx_byte), 32'd0);
    m_code = 8'h00; m_rx = 8'h00; m_ext = 1'b0;
    m_valid = 1'b0; m_extp = 1'b0; m_brkp = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    cyc(4);
    rst_n = 1'b1;
    cyc(20);
    check_all("midreset");
    send(8'h2A, 1'b0, 1'b1);
    check_all("after_reset");

    for (int i = 0; i < 8; i++) pool[i] = NOTE_KEYS[i];
    pool[8] = 8'hE0; pool[9] = 8'hF0; pool[10] = 8'hF0;
    pool[11] = 8'hAA; pool[12] = 8'hFA; pool[13] = 8'h74;
    for (int i = 0; i < 22; i++) begin
      if ($urandom_range(0, 5) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 13)];
      send(b, $urandom_range(0, 7) == 0, 1'b1);
      check_all($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
